axis_layer_sequencer: RTL and testbench

AXIS_LAYER_SEQUENCER -- requirements
Module: axis_layer_sequencer

---
 rtl/axis_layer_sequencer_pkg.sv | 29 ++
 rtl/axis_layer_sequencer_layer_cfg_table.sv | 51 +++++
 rtl/axis_layer_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_axis_layer_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: table field codes, FSM encoding
// and the default sizing of the table, DMA length and packet counter.
package axis_layer_sequencer_pkg;

    localparam int N_LAYERS_MAX_DEF = 16;
    localparam int ADDR_WIDTH_DEF   = 32;
    localparam int LEN_WIDTH_DEF    = 24;
    localparam int CNT_WIDTH_DEF    = 16;

    localparam logic [2:0] FIELD_PIX_ADDR = 3'd0;
    localparam logic [2:0] FIELD_PIX_LEN  = 3'd1;
    localparam logic [2:0] FIELD_WGT_ADDR = 3'd2;
    localparam logic [2:0] FIELD_WGT_LEN  = 3'd3;
    localparam logic [2:0] FIELD_OUT_PKTS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // A one-row table still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_layer_sequencer_layer_cfg_table.sv
// Per-layer configuration storage: one field-addressed write port and one
// combinational read port returning a whole row.
module layer_cfg_table
    import axis_layer_sequencer_pkg::*;
#(
    parameter int  N_LAYERS_MAX = N_LAYERS_MAX_DEF,
    parameter int  ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int  LEN_WIDTH    = LEN_WIDTH_DEF,
    parameter int  CNT_WIDTH    = CNT_WIDTH_DEF,
    localparam int IDX_W        = idx_width(N_LAYERS_MAX)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [2:0]            wfield,
    input  logic [31:0]           wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [ADDR_WIDTH-1:0] rd_pix_addr,
    output logic [LEN_WIDTH-1:0]  rd_pix_len,
    output logic [ADDR_WIDTH-1:0] rd_wgt_addr,
    output logic [LEN_WIDTH-1:0]  rd_wgt_len,
    output logic [CNT_WIDTH-1:0]  rd_out_pkts
);

    logic [ADDR_WIDTH-1:0] pix_addr_q [N_LAYERS_MAX];
    logic [LEN_WIDTH-1:0]  pix_len_q  [N_LAYERS_MAX];
    logic [ADDR_WIDTH-1:0] wgt_addr_q [N_LAYERS_MAX];
    logic [LEN_WIDTH-1:0]  wgt_len_q  [N_LAYERS_MAX];
    logic [CNT_WIDTH-1:0]  out_pkts_q [N_LAYERS_MAX];

    // Contents survive reset so a run can be restarted without reprogramming.
    always_ff @(posedge clk) begin
        if (we) begin
            case (wfield)
                FIELD_PIX_ADDR: pix_addr_q[waddr] <= ADDR_WIDTH'(wdata);
                FIELD_PIX_LEN:  pix_len_q[waddr]  <= LEN_WIDTH'(wdata);
                FIELD_WGT_ADDR: wgt_addr_q[waddr] <= ADDR_WIDTH'(wdata);
                FIELD_WGT_LEN:  wgt_len_q[waddr]  <= LEN_WIDTH'(wdata);
                FIELD_OUT_PKTS: out_pkts_q[waddr] <= CNT_WIDTH'(wdata);
                default: ;
            endcase
        end
    end

    assign rd_pix_addr = pix_addr_q[raddr];
    assign rd_pix_len  = pix_len_q[raddr];
    assign rd_wgt_addr = wgt_addr_q[raddr];
    assign rd_wgt_len  = wgt_len_q[raddr];
    assign rd_out_pkts = out_pkts_q[raddr];

endmodule

// File: rtl/axis_layer_sequencer.sv
// Walks the layer table: per layer issues the pixel and weight DMA commands,
// then waits for the programmed number of output packets before advancing.
module axis_layer_sequencer
    import axis_layer_sequencer_pkg::*;
#(
    parameter int  N_LAYERS_MAX = N_LAYERS_MAX_DEF,
    parameter int  ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int  LEN_WIDTH    = LEN_WIDTH_DEF,
    parameter int  CNT_WIDTH    = CNT_WIDTH_DEF,
    localparam int IDX_W        = idx_width(N_LAYERS_MAX)
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_layer,
    input  logic [2:0]            cfg_field,
    input  logic [31:0]           cfg_wdata,
    input  logic                  start,
    input  logic [IDX_W:0]        n_layers,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      layer_idx,
    output logic                  pix_cmd_valid,
    input  logic                  pix_cmd_ready,
    output logic [ADDR_WIDTH-1:0] pix_cmd_addr,
    output logic [LEN_WIDTH-1:0]  pix_cmd_len,
    output logic                  wgt_cmd_valid,
    input  logic                  wgt_cmd_ready,
    output logic [ADDR_WIDTH-1:0] wgt_cmd_addr,
    output logic [LEN_WIDTH-1:0]  wgt_cmd_len,
    input  logic                  mon_valid,
    input  logic                  mon_ready,
    input  logic                  mon_last
);

    localparam logic [IDX_W:0]     N_MAX_L = (IDX_W + 1)'(N_LAYERS_MAX);
    localparam logic [IDX_W:0]     ONE_L   = (IDX_W + 1)'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    seq_state_e            state_q;
    logic [IDX_W-1:0]      layer_idx_q;
    logic [IDX_W:0]        n_layers_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pix_vld_q;
    logic                  wgt_vld_q;
    logic                  pix_acc_q;
    logic                  wgt_acc_q;
    logic [ADDR_WIDTH-1:0] pix_addr_q;
    logic [LEN_WIDTH-1:0]  pix_len_q;
    logic [ADDR_WIDTH-1:0] wgt_addr_q;
    logic [LEN_WIDTH-1:0]  wgt_len_q;
    logic [CNT_WIDTH-1:0]  out_pkts_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;

    logic                  pix_acc_d;
    logic                  wgt_acc_d;
    logic                  start_ok;
    logic                  last_layer;
    logic                  pkt_beat;

    logic [ADDR_WIDTH-1:0] rd_pix_addr;
    logic [LEN_WIDTH-1:0]  rd_pix_len;
    logic [ADDR_WIDTH-1:0] rd_wgt_addr;
    logic [LEN_WIDTH-1:0]  rd_wgt_len;
    logic [CNT_WIDTH-1:0]  rd_out_pkts;

    layer_cfg_table #(
        .N_LAYERS_MAX (N_LAYERS_MAX),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .LEN_WIDTH    (LEN_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_table (
        .clk         (aclk),
        .we          (cfg_we),
        .waddr       (cfg_layer),
        .wfield      (cfg_field),
        .wdata       (cfg_wdata),
        .raddr       (layer_idx_q),
        .rd_pix_addr (rd_pix_addr),
        .rd_pix_len  (rd_pix_len),
        .rd_wgt_addr (rd_wgt_addr),
        .rd_wgt_len  (rd_wgt_len),
        .rd_out_pkts (rd_out_pkts)
    );

    assign pkt_beat   = mon_valid & mon_ready & mon_last;
    assign start_ok   = start && (n_layers != '0) && (n_layers <= N_MAX_L);
    assign last_layer = (({1'b0, layer_idx_q} + ONE_L) == n_layers_q);
    assign pix_acc_d  = pix_acc_q | (pix_vld_q & pix_cmd_ready);
    assign wgt_acc_d  = wgt_acc_q | (wgt_vld_q & wgt_cmd_ready);

    // Packet counter clears on LOAD and only listens while a layer is in flight.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_LOAD) begin
            cnt_d = '0;
        end else if ((state_q == ST_ISSUE || state_q == ST_WAIT) && pkt_beat && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            layer_idx_q <= '0;
            n_layers_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_vld_q   <= 1'b0;
            wgt_vld_q   <= 1'b0;
            pix_acc_q   <= 1'b0;
            wgt_acc_q   <= 1'b0;
            pix_addr_q  <= '0;
            pix_len_q   <= '0;
            wgt_addr_q  <= '0;
            wgt_len_q   <= '0;
            out_pkts_q  <= '0;
            cnt_q       <= '0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        n_layers_q  <= n_layers;
                        layer_idx_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    pix_addr_q <= rd_pix_addr;
                    pix_len_q  <= rd_pix_len;
                    wgt_addr_q <= rd_wgt_addr;
                    wgt_len_q  <= rd_wgt_len;
                    out_pkts_q <= rd_out_pkts;
                    // Zero-length commands are never shown and count as accepted.
                    pix_vld_q  <= (rd_pix_len != '0);
                    wgt_vld_q  <= (rd_wgt_len != '0);
                    pix_acc_q  <= (rd_pix_len == '0);
                    wgt_acc_q  <= (rd_wgt_len == '0);
                    state_q    <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    pix_acc_q <= pix_acc_d;
                    wgt_acc_q <= wgt_acc_d;
                    if (pix_vld_q && pix_cmd_ready) begin
                        pix_vld_q <= 1'b0;
                    end
                    if (wgt_vld_q && wgt_cmd_ready) begin
                        wgt_vld_q <= 1'b0;
                    end
                    if (pix_acc_d && wgt_acc_d) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q >= out_pkts_q) begin
                        if (last_layer) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            layer_idx_q <= layer_idx_q + 1'b1;
                            state_q     <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign layer_idx     = layer_idx_q;
    assign pix_cmd_valid = pix_vld_q;
    assign pix_cmd_addr  = pix_addr_q;
    assign pix_cmd_len   = pix_len_q;
    assign wgt_cmd_valid = wgt_vld_q;
    assign wgt_cmd_addr  = wgt_addr_q;
    assign wgt_cmd_len   = wgt_len_q;

endmodule

// File: tb/tb_axis_layer_sequencer.sv
// Directed bench for axis_layer_sequencer: single and multi-layer runs, command
// back-pressure, zero-length commands, ignored starts, mid-run reset and table rewrites.
module tb_axis_layer_sequencer;

    localparam int IDX_W = 4;

    logic              aclk;
    logic              rst;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_layer;
    logic [2:0]        cfg_field;
    logic [31:0]       cfg_wdata;
    logic              start;
    logic [IDX_W:0]    n_layers;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  layer_idx;
    logic              pix_cmd_valid;
    logic              pix_cmd_ready;
    logic [31:0]       pix_cmd_addr;
    logic [23:0]       pix_cmd_len;
    logic              wgt_cmd_valid;
    logic              wgt_cmd_ready;
    logic [31:0]       wgt_cmd_addr;
    logic [23:0]       wgt_cmd_len;
    logic              mon_valid;
    logic              mon_ready;
    logic              mon_last;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int wgt_hs_cnt = 0;

    axis_layer_sequencer dut (
        .aclk          (aclk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_layer     (cfg_layer),
        .cfg_field     (cfg_field),
        .cfg_wdata     (cfg_wdata),
        .start         (start),
        .n_layers      (n_layers),
        .busy          (busy),
        .done          (done),
        .layer_idx     (layer_idx),
        .pix_cmd_valid (pix_cmd_valid),
        .pix_cmd_ready (pix_cmd_ready),
        .pix_cmd_addr  (pix_cmd_addr),
        .pix_cmd_len   (pix_cmd_len),
        .wgt_cmd_valid (wgt_cmd_valid),
        .wgt_cmd_ready (wgt_cmd_ready),
        .wgt_cmd_addr  (wgt_cmd_addr),
        .wgt_cmd_len   (wgt_cmd_len),
        .mon_valid     (mon_valid),
        .mon_ready     (mon_ready),
        .mon_last      (mon_last)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (done === 1'b1) done_cnt++;
        if (wgt_cmd_valid === 1'b1 && wgt_cmd_ready === 1'b1) wgt_hs_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int row, input logic [2:0] fld, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_layer = IDX_W'(row);
        cfg_field = fld;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic send_tlast(input int n);
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        mon_last  = 1'b1;
        repeat (n) tick();
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        mon_last  = 1'b0;
    endtask

    task automatic wait_pix(input string tag);
        int k = 0;
        while (pix_cmd_valid !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check(tag, pix_cmd_valid, 1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check(tag, done, 1);
    endtask

    task automatic pulse_start(input int n);
        start    = 1'b1;
        n_layers = (IDX_W + 1)'(n);
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int d0;
        int w0;
        rst = 1'b1; cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_wdata = '0;
        start = 1'b0; n_layers = '0; pix_cmd_ready = 1'b1; wgt_cmd_ready = 1'b1;
        mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;

        // Reset state
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", layer_idx, 0);
        check("rst_pix_vld", pix_cmd_valid, 0);
        check("rst_wgt_vld", wgt_cmd_valid, 0);
        check("rst_pix_addr", pix_cmd_addr, 0);
        tick();
        rst = 1'b0;

        // Table: row 0 pix_len written with upper junk that must be truncated
        cfg_write(0, 3'd0, 32'h0000_1000);
        cfg_write(0, 3'd1, 32'hAB00_0100);
        cfg_write(0, 3'd2, 32'h0000_8000);
        cfg_write(0, 3'd3, 32'd64);
        cfg_write(0, 3'd4, 32'd4);
        cfg_write(0, 3'd5, 32'hFFFF_FFFF);
        cfg_write(1, 3'd0, 32'h0000_2000);
        cfg_write(1, 3'd1, 32'd128);
        cfg_write(1, 3'd2, 32'h0000_9000);
        cfg_write(1, 3'd3, 32'd32);
        cfg_write(1, 3'd4, 32'd1);
        cfg_write(2, 3'd0, 32'h0000_3000);
        cfg_write(2, 3'd1, 32'd16);
        cfg_write(2, 3'd2, 32'h0000_A000);
        cfg_write(2, 3'd3, 32'd8);
        cfg_write(2, 3'd4, 32'd2);
        check("idle_after_cfg", busy, 0);

        // Single layer, readies high
        d0 = done_cnt;
        pulse_start(1);
        check("t1_load_busy", busy, 1);
        check("t1_load_pix_vld", pix_cmd_valid, 0);
        tick();
        check("t1_pix_vld", pix_cmd_valid, 1);
        check("t1_pix_addr", pix_cmd_addr, 32'h1000);
        check("t1_pix_len", pix_cmd_len, 256);
        check("t1_wgt_vld", wgt_cmd_valid, 1);
        check("t1_wgt_addr", wgt_cmd_addr, 32'h8000);
        check("t1_wgt_len", wgt_cmd_len, 64);
        check("t1_idx", layer_idx, 0);
        tick();
        check("t1_pix_vld_drop", pix_cmd_valid, 0);
        check("t1_wgt_vld_drop", wgt_cmd_valid, 0);
        mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b0;
        tick();
        mon_valid = 1'b1; mon_ready = 1'b0; mon_last = 1'b1;
        tick();
        send_tlast(4);
        check("t1_done_early", done, 0);
        check("t1_busy_wait", busy, 1);
        tick();
        check("t1_done", done, 1);
        check("t1_busy_done", busy, 0);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_done_count", done_cnt - d0, 1);

        // Three layers, weight command back-pressured for 10 cycles
        d0 = done_cnt;
        wgt_cmd_ready = 1'b0;
        pulse_start(3);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t2_wgt_hold_vld", wgt_cmd_valid, 1);
            check("t2_wgt_hold_addr", wgt_cmd_addr, 32'h8000);
            check("t2_wgt_hold_len", wgt_cmd_len, 64);
            if (i == 1) check("t2_pix_taken", pix_cmd_valid, 0);
            tick();
        end
        check("t2_idx0", layer_idx, 0);
        wgt_cmd_ready = 1'b1;
        tick();
        check("t2_wgt_drop", wgt_cmd_valid, 0);
        send_tlast(4);
        wait_pix("t2_l1_pix");
        check("t2_idx1", layer_idx, 1);
        check("t2_l1_pix_addr", pix_cmd_addr, 32'h2000);
        check("t2_l1_pix_len", pix_cmd_len, 128);
        check("t2_l1_wgt_addr", wgt_cmd_addr, 32'h9000);
        check("t2_l1_wgt_len", wgt_cmd_len, 32);
        send_tlast(1);
        wait_pix("t2_l2_pix");
        check("t2_idx2", layer_idx, 2);
        check("t2_l2_pix_addr", pix_cmd_addr, 32'h3000);
        check("t2_l2_wgt_len", wgt_cmd_len, 8);
        send_tlast(2);
        wait_done("t2_done");
        tick();
        tick();
        check("t2_done_count", done_cnt - d0, 1);

        // Zero-length weight command and zero out_pkts
        cfg_write(0, 3'd3, 32'd0);
        cfg_write(0, 3'd4, 32'd0);
        w0 = wgt_hs_cnt;
        pulse_start(1);
        tick();
        check("t3_pix_vld", pix_cmd_valid, 1);
        check("t3_wgt_vld", wgt_cmd_valid, 0);
        tick();
        check("t3_done_wait", done, 0);
        check("t3_busy", busy, 1);
        tick();
        check("t3_done", done, 1);
        check("t3_no_wgt", wgt_hs_cnt - w0, 0);
        tick();
        cfg_write(0, 3'd3, 32'd64);
        cfg_write(0, 3'd4, 32'd4);

        // Starts while busy and with out-of-range counts are ignored
        pix_cmd_ready = 1'b0;
        pulse_start(2);
        tick();
        start = 1'b1;
        n_layers = 5'd1;
        tick();
        start = 1'b0;
        check("t4_busy_held", busy, 1);
        check("t4_idx_held", layer_idx, 0);
        check("t4_pix_held", pix_cmd_valid, 1);
        check("t4_wgt_taken", wgt_cmd_valid, 0);
        pix_cmd_ready = 1'b1;
        tick();
        send_tlast(4);
        wait_pix("t4_l1_pix");
        check("t4_idx1", layer_idx, 1);
        send_tlast(1);
        wait_done("t4_done");
        tick();
        pulse_start(0);
        check("t4_n0_busy", busy, 0);
        check("t4_n0_idx", layer_idx, 1);
        tick();
        check("t4_n0_pix", pix_cmd_valid, 0);
        pulse_start(17);
        check("t4_n17_busy", busy, 0);
        tick();
        check("t4_n17_pix", pix_cmd_valid, 0);

        // Reset in WAIT of the second layer aborts without done
        d0 = done_cnt;
        pulse_start(2);
        tick();
        tick();
        send_tlast(4);
        wait_pix("t5_l1_pix");
        tick();
        check("t5_wait_busy", busy, 1);
        check("t5_wait_idx", layer_idx, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_idx", layer_idx, 0);
        check("t5_rst_pix_vld", pix_cmd_valid, 0);
        check("t5_rst_wgt_vld", wgt_cmd_valid, 0);
        check("t5_rst_pix_addr", pix_cmd_addr, 0);
        check("t5_rst_pix_len", pix_cmd_len, 0);
        check("t5_rst_wgt_addr", wgt_cmd_addr, 0);
        check("t5_rst_wgt_len", wgt_cmd_len, 0);
        tick();
        tick();
        tick();
        check("t5_no_done", done_cnt - d0, 0);
        pulse_start(2);
        tick();
        check("t5_re_pix_addr", pix_cmd_addr, 32'h1000);
        check("t5_re_pix_len", pix_cmd_len, 256);
        check("t5_re_wgt_len", wgt_cmd_len, 64);
        tick();
        send_tlast(4);
        wait_pix("t5_re_l1_pix");
        check("t5_re_l1_addr", pix_cmd_addr, 32'h2000);
        send_tlast(1);
        wait_done("t5_re_done");
        tick();
        check("t5_re_done_count", done_cnt - d0, 1);

        // Rewrite of the active row during WAIT only affects the next run
        pulse_start(1);
        tick();
        tick();
        cfg_write(0, 3'd1, 32'h40);
        check("t6_len_kept", pix_cmd_len, 256);
        check("t6_busy", busy, 1);
        send_tlast(4);
        wait_done("t6_done1");
        tick();
        pulse_start(1);
        tick();
        check("t6_new_pix_vld", pix_cmd_valid, 1);
        check("t6_new_pix_len", pix_cmd_len, 24'h40);
        check("t6_new_pix_addr", pix_cmd_addr, 32'h1000);
        tick();
        send_tlast(4);
        wait_done("t6_done2");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
